dcache_write_buffer: RTL and testbench
======================================

Name: dcache_write_buffer

Overview:
- FIFO write buffer between the data Cache's write port (wr_req/wr_type/wr_addr/wr_wstrb/wr_data/wr_rdy) and the data-write port of cpu_axi_interface.
- Absorbs dirty-line writebacks and uncached stores so the Cache can proceed with its refill read without waiting for the AXI B response.
- Issues one write at a time, in order.
- Flags read-after-write conflicts so the Cache can stall a refill or uncached read that targets a pending write.

Parameters:
- DEPTH, 4, number of buffered entries; power of 2, minimum 2.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_wr_req  in  1  Cache write request.
- in_wr_type  in  3  000 byte, 001 half, 010 word, 100 16-byte line.
- in_wr_addr  in  32  physical address.
- in_wr_wstrb  in  4  byte strobes; meaningful for non-line types only.
- in_wr_data  in  128  line data; non-line types use [31:0].
- in_wr_rdy  out  1  buffer can accept a write this cycle.
- out_wr_req  out  1  write request to AXI interface.
- out_wr_type  out  3  head entry type.
- out_wr_addr  out  32  head entry address.
- out_wr_wstrb  out  4  head entry strobes.
- out_wr_data  out  128  head entry data.
- out_wr_rdy  in  1  AXI interface accepts the presented write.
- out_wr_done  in  1  one-cycle pulse when the B response for the accepted write returns.
- rd_chk_addr  in  32  address of a read the Cache intends to issue.
- rd_conflict  out  1  rd_chk_addr[31:4] matches a pending write.
- empty  out  1  no entries queued and nothing in flight.

Behaviour:
- Handshakes:
  - Push on in_wr_req && in_wr_rdy.
  - Issue on out_wr_req && out_wr_rdy.
  - in_wr_rdy = (count != DEPTH) && !reset; it must not depend on in_wr_req.
- Storage: circular FIFO with wr_ptr, rd_ptr (AW bits, wrap modulo DEPTH) and count (AW+1 bits).
- Reset (synchronous, applied on the clk edge with reset high):
  - ptrs = 0, count = 0, state = IDLE, inflight_addr = 0.
  - out_wr_req = 0, empty = 1, rd_conflict = 0.
  - Queued and in-flight writes are discarded, including a reset mid-transaction.
- FSM states:
  - IDLE: out_wr_req = 0. Go to ISSUE when count != 0.
  - ISSUE: out_wr_req = 1, with the head entry driven on the out_wr_* fields. Request and fields stay stable until out_wr_rdy. On acceptance: pop the head, latch inflight_addr = head addr, go to WAIT_DONE.
  - WAIT_DONE: out_wr_req = 0. On out_wr_done, go to ISSUE if count != 0 (after any same-cycle push), else IDLE.
- Latency:
  - A push into an empty, idle buffer gives out_wr_req = 1 on the second edge after the push: IDLE sees count = 1, then ISSUE.
  - No combinational bypass from in to out.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push while full is impossible because in_wr_rdy = 0.
  - out_wr_done outside WAIT_DONE is ignored.
- rd_conflict (combinational) is 1 if rd_chk_addr[31:4] equals addr[31:4] of any of:
  - a valid FIFO entry;
  - inflight_addr while in WAIT_DONE;
  - in_wr_addr during a push in the same cycle.
  - Comparison is line-granular for all types.
- empty = (count == 0) && state != WAIT_DONE && state != ISSUE.
- Ordering: writes reach AXI strictly in push order. At most one write is outstanding.

Test Plan:
- Reset then idle: after reset, in_wr_rdy = 1, out_wr_req = 0, empty = 1, rd_conflict = 0 for any rd_chk_addr.
- Single line writeback: push type 100, addr 0x1FC0_0120, data 128'h0123…CDEF → out_wr_req rises two cycles later with identical fields. Hold out_wr_rdy = 0 for 3 cycles; fields stay stable. Assert out_wr_rdy → out_wr_req drops. Pulse out_wr_done → empty = 1.
- Fill: push 4 writes (0x100, 0x200, 0x300, 0x400) with out_wr_rdy = 0 → in_wr_rdy = 0 after the 4th. A 5th in_wr_req is not accepted. Drain gives AXI order 0x100, 0x200, 0x300, 0x400.
- Conflict: pending 0x0000_1230 → rd_chk_addr 0x0000_123C gives rd_conflict = 1, 0x0000_1240 gives 0. While the entry is in WAIT_DONE it is still 1; the cycle after out_wr_done it is 0.
- Simultaneous push/pop with count = 2 → count stays 2 and the pointers wrap correctly past index 3 to 0.
- Reset asserted during WAIT_DONE with 2 queued → next cycle empty = 1, out_wr_req = 0. A later out_wr_done is ignored.

Source files
------------

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer
//    FIFO write buffer between the data Cache write port and the data-write
//    port of the AXI interface. Dirty-line writebacks and uncached stores are
//    queued here so the Cache can start its refill read without waiting for
//    the AXI B response. Writes are issued one at a time, strictly in push
//    order, with at most one write outstanding. A line-granular address
//    checker flags reads that would overtake a pending write.
//
// Ports
//    clk, reset          clock, synchronous active-high reset
//    in_wr_*             Cache-side write request (req/type/addr/wstrb/data/rdy)
//    out_wr_*            AXI-side write request (req/type/addr/wstrb/data/rdy)
//    out_wr_done         one-cycle pulse when the accepted write's B response returns
//    rd_chk_addr         address of a read the Cache intends to issue
//    rd_conflict         rd_chk_addr hits the same 16-byte line as a pending write
//    empty               nothing queued and nothing in flight
module dcache_write_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_wr_req,
   input  logic [2:0]   in_wr_type,
   input  logic [31:0]  in_wr_addr,
   input  logic [3:0]   in_wr_wstrb,
   input  logic [127:0] in_wr_data,
   output logic         in_wr_rdy,
   output logic         out_wr_req,
   output logic [2:0]   out_wr_type,
   output logic [31:0]  out_wr_addr,
   output logic [3:0]   out_wr_wstrb,
   output logic [127:0] out_wr_data,
   input  logic         out_wr_rdy,
   input  logic         out_wr_done,
   input  logic [31:0]  rd_chk_addr,
   output logic         rd_conflict,
   output logic         empty
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   localparam logic [AW:0]  FULL_COUNT = (AW+1)'(DEPTH);
   // Conflicts are judged per 16-byte line, whatever the write type.
   localparam logic [31:0]  LINE_MASK  = 32'hFFFF_FFF0;

   state_t          state;
   state_t          state_next;

   logic [2:0]      type_q  [DEPTH];
   logic [31:0]     addr_q  [DEPTH];
   logic [3:0]      wstrb_q [DEPTH];
   logic [127:0]    data_q  [DEPTH];

   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic [31:0]     inflight_addr;

   logic            push;
   logic            pop;
   logic [AW-1:0]   offset;

   // Ready depends only on occupancy and reset, never on the request itself.
   assign in_wr_rdy = (count != FULL_COUNT) && !reset;
   assign push      = in_wr_req && in_wr_rdy;
   assign pop       = (state == ISSUE) && out_wr_rdy;

   // The head entry is presented directly from storage; it cannot change while
   // ISSUE waits because only a pop moves rd_ptr.
   assign out_wr_type  = type_q[rd_ptr];
   assign out_wr_addr  = addr_q[rd_ptr];
   assign out_wr_wstrb = wstrb_q[rd_ptr];
   assign out_wr_data  = data_q[rd_ptr];

   // Entry storage: no reset needed, validity is tracked by count/pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         type_q[wr_ptr]  <= in_wr_type;
         addr_q[wr_ptr]  <= in_wr_addr;
         wstrb_q[wr_ptr] <= in_wr_wstrb;
         data_q[wr_ptr]  <= in_wr_data;
      end
   end

   // Pointers, occupancy and the address of the write awaiting its B response.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         inflight_addr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr        <= rd_ptr + 1'b1;
            inflight_addr <= out_wr_addr;
         end
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. In WAIT_DONE nothing can pop, so the occupancy after a
   // same-cycle push is simply count plus push.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (count != '0) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (out_wr_rdy) begin
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (out_wr_done) begin
               if ((count != '0) || push) begin
                  state_next = ISSUE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      out_wr_req = (state == ISSUE);
      empty      = (count == '0) && (state != WAIT_DONE) && (state != ISSUE);
   end

   // Read-after-write checker. Slot i is valid when its distance from rd_ptr
   // (modulo DEPTH) is below count; the in-flight write and a write being
   // pushed this very cycle also count as pending.
   always_comb begin
      rd_conflict = 1'b0;
      offset      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset = AW'(i) - rd_ptr;
         if (({1'b0, offset} < count) &&
             ((addr_q[i] & LINE_MASK) == (rd_chk_addr & LINE_MASK))) begin
            rd_conflict = 1'b1;
         end
      end
      if ((state == WAIT_DONE) &&
          ((inflight_addr & LINE_MASK) == (rd_chk_addr & LINE_MASK))) begin
         rd_conflict = 1'b1;
      end
      if (push && ((in_wr_addr & LINE_MASK) == (rd_chk_addr & LINE_MASK))) begin
         rd_conflict = 1'b1;
      end
   end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer
//    Directed bench for dcache_write_buffer: reset state, single line
//    writeback with back-pressure, fill to full and in-order drain, line
//    conflict detection, simultaneous push/pop across the pointer wrap, and
//    reset in the middle of a transaction.
module tb_dcache_write_buffer;

   logic         clk;
   logic         reset;
   logic         in_wr_req;
   logic [2:0]   in_wr_type;
   logic [31:0]  in_wr_addr;
   logic [3:0]   in_wr_wstrb;
   logic [127:0] in_wr_data;
   logic         in_wr_rdy;
   logic         out_wr_req;
   logic [2:0]   out_wr_type;
   logic [31:0]  out_wr_addr;
   logic [3:0]   out_wr_wstrb;
   logic [127:0] out_wr_data;
   logic         out_wr_rdy;
   logic         out_wr_done;
   logic [31:0]  rd_chk_addr;
   logic         rd_conflict;
   logic         empty;

   int compared;
   int mismatched;

   localparam logic [127:0] LINE_DATA = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

   dcache_write_buffer #(.DEPTH(4), .AW(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_wr_req    (in_wr_req),
      .in_wr_type   (in_wr_type),
      .in_wr_addr   (in_wr_addr),
      .in_wr_wstrb  (in_wr_wstrb),
      .in_wr_data   (in_wr_data),
      .in_wr_rdy    (in_wr_rdy),
      .out_wr_req   (out_wr_req),
      .out_wr_type  (out_wr_type),
      .out_wr_addr  (out_wr_addr),
      .out_wr_wstrb (out_wr_wstrb),
      .out_wr_data  (out_wr_data),
      .out_wr_rdy   (out_wr_rdy),
      .out_wr_done  (out_wr_done),
      .rd_chk_addr  (rd_chk_addr),
      .rd_conflict  (rd_conflict),
      .empty        (empty)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something never terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample and drive 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one write on the Cache side for exactly one edge.
   task automatic applyStimulus(input logic [2:0] t, input logic [31:0] a,
                                input logic [3:0] s, input logic [127:0] d);
      in_wr_req   = 1'b1;
      in_wr_type  = t;
      in_wr_addr  = a;
      in_wr_wstrb = s;
      in_wr_data  = d;
      tick();
      in_wr_req   = 1'b0;
   endtask

   // Wait (bounded) for a request, check its address, accept it and return its B response.
   task automatic drainOne(input logic [31:0] exp_addr, input string tag);
      int n;
      n = 0;
      while (!out_wr_req && n < 10) begin
         tick();
         n++;
      end
      checkOutput({tag, "_req"}, out_wr_req, 1'b1);
      checkOutput({tag, "_addr"}, out_wr_addr, exp_addr);
      out_wr_rdy = 1'b1;
      tick();
      out_wr_rdy = 1'b0;
      checkOutput({tag, "_req_drop"}, out_wr_req, 1'b0);
      out_wr_done = 1'b1;
      tick();
      out_wr_done = 1'b0;
   endtask

   initial begin
      compared    = 0;
      mismatched  = 0;
      reset       = 1'b1;
      in_wr_req   = 1'b0;
      in_wr_type  = 3'b000;
      in_wr_addr  = 32'h0;
      in_wr_wstrb = 4'h0;
      in_wr_data  = '0;
      out_wr_rdy  = 1'b0;
      out_wr_done = 1'b0;
      rd_chk_addr = 32'h0;
      tick();
      tick();
      reset = 1'b0;
      #1;

      // Reset then idle.
      checkOutput("rst_in_rdy", in_wr_rdy, 1'b1);
      checkOutput("rst_out_req", out_wr_req, 1'b0);
      checkOutput("rst_empty", empty, 1'b1);
      checkOutput("rst_conflict_0", rd_conflict, 1'b0);
      rd_chk_addr = 32'hFFFF_FFF0;
      #1;
      checkOutput("rst_conflict_ff", rd_conflict, 1'b0);

      // Single line writeback; conflict is visible during the push cycle itself.
      rd_chk_addr = 32'h1FC0_0128;
      in_wr_req   = 1'b1;
      in_wr_type  = 3'b100;
      in_wr_addr  = 32'h1FC0_0120;
      in_wr_wstrb = 4'hF;
      in_wr_data  = LINE_DATA;
      #1;
      checkOutput("line_push_conflict", rd_conflict, 1'b1);
      tick();
      in_wr_req = 1'b0;
      checkOutput("line_req_edge1", out_wr_req, 1'b0);
      checkOutput("line_not_empty", empty, 1'b0);
      tick();
      checkOutput("line_req_edge2", out_wr_req, 1'b1);
      checkOutput("line_type", out_wr_type, 3'b100);
      checkOutput("line_addr", out_wr_addr, 32'h1FC0_0120);
      checkOutput("line_data", out_wr_data, LINE_DATA);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("line_hold_req", out_wr_req, 1'b1);
         checkOutput("line_hold_addr", out_wr_addr, 32'h1FC0_0120);
         checkOutput("line_hold_data", out_wr_data, LINE_DATA);
      end
      out_wr_rdy = 1'b1;
      tick();
      out_wr_rdy = 1'b0;
      rd_chk_addr = 32'h1FC0_0120;
      #1;
      checkOutput("line_req_drop", out_wr_req, 1'b0);
      checkOutput("line_wait_not_empty", empty, 1'b0);
      checkOutput("line_wait_conflict", rd_conflict, 1'b1);
      out_wr_done = 1'b1;
      tick();
      out_wr_done = 1'b0;
      checkOutput("line_done_empty", empty, 1'b1);
      checkOutput("line_done_conflict", rd_conflict, 1'b0);

      // Fill to full with AXI stalled.
      applyStimulus(3'b010, 32'h0000_0100, 4'hF, 128'h1);
      applyStimulus(3'b010, 32'h0000_0200, 4'hF, 128'h2);
      applyStimulus(3'b010, 32'h0000_0300, 4'hF, 128'h3);
      checkOutput("fill_rdy_3", in_wr_rdy, 1'b1);
      applyStimulus(3'b010, 32'h0000_0400, 4'hF, 128'h4);
      checkOutput("fill_rdy_4", in_wr_rdy, 1'b0);
      in_wr_req   = 1'b1;
      in_wr_addr  = 32'h0000_0500;
      rd_chk_addr = 32'h0000_0500;
      #1;
      checkOutput("fill_5th_rdy", in_wr_rdy, 1'b0);
      checkOutput("fill_5th_conflict", rd_conflict, 1'b0);
      tick();
      in_wr_req = 1'b0;
      rd_chk_addr = 32'h0000_0304;
      #1;
      checkOutput("fill_conflict_300", rd_conflict, 1'b1);
      drainOne(32'h0000_0100, "fill_d0");
      checkOutput("fill_rdy_after_pop", in_wr_rdy, 1'b1);
      drainOne(32'h0000_0200, "fill_d1");
      drainOne(32'h0000_0300, "fill_d2");
      drainOne(32'h0000_0400, "fill_d3");
      checkOutput("fill_empty", empty, 1'b1);

      // Line-granular conflict through queue, in-flight and completion.
      rd_chk_addr = 32'h0000_123C;
      applyStimulus(3'b010, 32'h0000_1230, 4'hF, 128'h1230);
      checkOutput("cf_queued_hit", rd_conflict, 1'b1);
      rd_chk_addr = 32'h0000_1240;
      #1;
      checkOutput("cf_next_line_miss", rd_conflict, 1'b0);
      rd_chk_addr = 32'h0000_123C;
      tick();
      checkOutput("cf_issue_req", out_wr_req, 1'b1);
      out_wr_rdy = 1'b1;
      tick();
      out_wr_rdy = 1'b0;
      checkOutput("cf_inflight_hit", rd_conflict, 1'b1);
      out_wr_done = 1'b1;
      tick();
      out_wr_done = 1'b0;
      checkOutput("cf_after_done", rd_conflict, 1'b0);
      checkOutput("cf_empty", empty, 1'b1);

      // Simultaneous push/pop at count 2, wrapping the write pointer to slot 0.
      applyStimulus(3'b010, 32'h0000_0A00, 4'h1, 128'hA);
      applyStimulus(3'b010, 32'h0000_0B00, 4'h2, 128'hB);
      checkOutput("sim_req", out_wr_req, 1'b1);
      checkOutput("sim_head_a", out_wr_addr, 32'h0000_0A00);
      out_wr_rdy = 1'b1;
      applyStimulus(3'b010, 32'h0000_0C00, 4'h4, 128'hC);
      out_wr_rdy = 1'b0;
      checkOutput("sim_req_drop", out_wr_req, 1'b0);
      checkOutput("sim_rdy", in_wr_rdy, 1'b1);
      rd_chk_addr = 32'h0000_0C08;
      #1;
      checkOutput("sim_wrapped_hit", rd_conflict, 1'b1);
      applyStimulus(3'b010, 32'h0000_0D00, 4'h8, 128'hD);
      checkOutput("sim_count3_rdy", in_wr_rdy, 1'b1);
      applyStimulus(3'b010, 32'h0000_0E00, 4'h3, 128'hE);
      checkOutput("sim_count4_rdy", in_wr_rdy, 1'b0);
      out_wr_done = 1'b1;
      tick();
      out_wr_done = 1'b0;
      checkOutput("sim_head_b_wstrb", out_wr_wstrb, 4'h2);
      drainOne(32'h0000_0B00, "sim_b");
      checkOutput("sim_head_c_data", out_wr_data, 128'hC);
      drainOne(32'h0000_0C00, "sim_c");
      drainOne(32'h0000_0D00, "sim_d");
      drainOne(32'h0000_0E00, "sim_e");
      checkOutput("sim_empty", empty, 1'b1);

      // Reset while a write is in flight and two more are queued.
      applyStimulus(3'b010, 32'h0000_0700, 4'hF, 128'h7);
      applyStimulus(3'b010, 32'h0000_0800, 4'hF, 128'h8);
      applyStimulus(3'b010, 32'h0000_0900, 4'hF, 128'h9);
      checkOutput("mid_req", out_wr_req, 1'b1);
      out_wr_rdy = 1'b1;
      tick();
      out_wr_rdy = 1'b0;
      checkOutput("mid_wait_not_empty", empty, 1'b0);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_in_rdy", in_wr_rdy, 1'b0);
      tick();
      reset = 1'b0;
      rd_chk_addr = 32'h0000_0800;
      #1;
      checkOutput("mid_empty", empty, 1'b1);
      checkOutput("mid_req_low", out_wr_req, 1'b0);
      checkOutput("mid_conflict", rd_conflict, 1'b0);
      out_wr_done = 1'b1;
      tick();
      out_wr_done = 1'b0;
      checkOutput("mid_done_ignored_empty", empty, 1'b1);
      tick();
      checkOutput("mid_done_ignored_req", out_wr_req, 1'b0);

      // Buffer is usable again after the mid-transaction reset.
      applyStimulus(3'b001, 32'h0000_0600, 4'h3, 128'h6);
      drainOne(32'h0000_0600, "post_rst");
      checkOutput("post_rst_empty", empty, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
